// File: rtl/lcd_pkg.sv
// Shared constants, state encodings and decode helpers for the HD44780 character writer.
package lcd_pkg;

  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DDRAM     = 8'h80;

  localparam logic [7:0] LINE0_BASE = 8'h00;
  localparam logic [7:0] LINE1_BASE = 8'h40;

  localparam logic [7:0] CHAR_CR = 8'h0D;
  localparam logic [7:0] CHAR_LF = 8'h0A;
  localparam logic [7:0] CHAR_FF = 8'h0C;

  localparam logic [2:0] INIT_LEN = 3'd4;

  typedef enum logic [2:0] {
    ST_PWRUP = 3'd0,
    ST_INIT  = 3'd1,
    ST_IDLE  = 3'd2,
    ST_XFER  = 3'd3,
    ST_WRAP  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    PH_SETUP = 2'd0,
    PH_PULSE = 2'd1,
    PH_EXEC  = 2'd2
  } phase_t;

  function automatic logic [7:0] line_base(input logic line);
    return line ? LINE1_BASE : LINE0_BASE;
  endfunction

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    logic [7:0] cmd;
    case (idx)
      3'd0:    cmd = CMD_FUNC_8B2L;
      3'd1:    cmd = CMD_DISP_ON;
      3'd2:    cmd = CMD_CLEAR;
      3'd3:    cmd = CMD_ENTRY;
      default: cmd = CMD_ENTRY;
    endcase
    return cmd;
  endfunction

  function automatic logic is_printable(input logic [7:0] b);
    return (b >= 8'h20) && (b <= 8'h7E);
  endfunction

endpackage

// File: rtl/lcd_bus_xfer.sv
// One HD44780 bus write: SETUP (EN low), PULSE (EN high), EXEC (EN low) timed by a reloading counter.
module lcd_bus_xfer
  import lcd_pkg::*;
#(
  parameter int CYC_US  = 27,
  parameter int EXEC_US = 50,
  parameter int LONG_US = 2000,
  parameter int CNT_W   = 21,
  parameter int DATA_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              rs,
  input  logic [DATA_W-1:0] data,
  input  logic              long_wait,
  output logic              done,
  output logic              busy,
  output logic              lcd_rs,
  output logic              lcd_en,
  output logic [DATA_W-1:0] lcd_data
);

  localparam logic [CNT_W-1:0] PHASE_LD = CNT_W'(CYC_US - 1);
  localparam logic [CNT_W-1:0] EXEC_LD  = CNT_W'(EXEC_US * CYC_US - 1);
  localparam logic [CNT_W-1:0] LONG_LD  = CNT_W'(LONG_US * CYC_US - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  phase_t              phase_r;
  logic [CNT_W-1:0]    cnt_r;
  logic                busy_r;
  logic                long_r;
  logic                rs_r;
  logic                en_r;
  logic [DATA_W-1:0]   data_r;

  // Done is combinational so the caller can chain the next write in the same cycle.
  assign done     = busy_r && (phase_r == PH_EXEC) && (cnt_r == CNT_ZERO);
  assign busy     = busy_r;
  assign lcd_rs   = rs_r;
  assign lcd_en   = en_r;
  assign lcd_data = data_r;

  // Phase sequencing, counter reload on each phase entry, and registered bus drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_r <= PH_SETUP;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      long_r  <= 1'b0;
      rs_r    <= 1'b0;
      en_r    <= 1'b0;
      data_r  <= {DATA_W{1'b0}};
    end else if (start) begin
      phase_r <= PH_SETUP;
      cnt_r   <= PHASE_LD;
      busy_r  <= 1'b1;
      long_r  <= long_wait;
      rs_r    <= rs;
      en_r    <= 1'b0;
      data_r  <= data;
    end else if (busy_r) begin
      case (phase_r)
        PH_SETUP: begin
          if (cnt_r == CNT_ZERO) begin
            phase_r <= PH_PULSE;
            cnt_r   <= PHASE_LD;
            en_r    <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        PH_PULSE: begin
          if (cnt_r == CNT_ZERO) begin
            phase_r <= PH_EXEC;
            cnt_r   <= long_r ? LONG_LD : EXEC_LD;
            en_r    <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        PH_EXEC: begin
          if (cnt_r == CNT_ZERO) begin
            busy_r <= 1'b0;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: begin
          busy_r <= 1'b0;
          en_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/lcd_char_writer.sv
// Byte-stream to HD44780 writer: power-up wait, init ROM, character/control decode and line wrap.
module lcd_char_writer
  import lcd_pkg::*;
#(
  parameter int CLK_HZ       = 27_000_000,
  parameter int PAYLOAD_BITS = 8,
  parameter int LCD_DATA_W   = 8,
  parameter int COLS         = 16,
  parameter int PWRUP_US     = 40000,
  parameter int EXEC_US      = 50,
  parameter int LONG_US      = 2000
) (
  input  logic                    CLK_I,
  input  logic                    RST_I,
  input  logic [PAYLOAD_BITS-1:0] DATA_I,
  input  logic                    VLD_I,
  output logic                    RDY_O,
  output logic                    DROP_O,
  output logic                    LCD_RS_O,
  output logic                    LCD_RW_O,
  output logic                    LCD_EN_O,
  output logic [LCD_DATA_W-1:0]   LCD_DATA_O
);

  localparam int CYC_US = CLK_HZ / 1_000_000;
  localparam int MAX_US = (PWRUP_US > LONG_US) ? PWRUP_US : LONG_US;
  localparam int CNT_W  = $clog2(MAX_US * CYC_US);
  localparam int COL_W  = $clog2(COLS + 1);

  localparam logic [CNT_W-1:0] PWRUP_LD = CNT_W'(PWRUP_US * CYC_US - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [COL_W-1:0] COL_ZERO = {COL_W{1'b0}};
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [COL_W-1:0] COL_MAX  = COL_W'(COLS);

  state_t                state_r, state_n;
  logic [CNT_W-1:0]      cnt_r, cnt_n;
  logic [2:0]            idx_r, idx_n;
  logic [COL_W-1:0]      col_r, col_n;
  logic                  line_r, line_n;
  logic                  rdy_r;
  logic                  drop_r;

  logic                  start_s;
  logic                  rs_s;
  logic [LCD_DATA_W-1:0] data_s;
  logic                  long_s;
  logic                  xfer_done_s;
  logic                  xfer_busy_s;

  lcd_bus_xfer #(
    .CYC_US  (CYC_US),
    .EXEC_US (EXEC_US),
    .LONG_US (LONG_US),
    .CNT_W   (CNT_W),
    .DATA_W  (LCD_DATA_W)
  ) u_xfer (
    .clk       (CLK_I),
    .rst       (RST_I),
    .start     (start_s),
    .rs        (rs_s),
    .data      (data_s),
    .long_wait (long_s),
    .done      (xfer_done_s),
    .busy      (xfer_busy_s),
    .lcd_rs    (LCD_RS_O),
    .lcd_en    (LCD_EN_O),
    .lcd_data  (LCD_DATA_O)
  );

  assign RDY_O    = rdy_r;
  assign DROP_O   = drop_r;
  assign LCD_RW_O = 1'b0;

  // Next-state, write request and cursor bookkeeping.
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    idx_n   = idx_r;
    col_n   = col_r;
    line_n  = line_r;
    start_s = 1'b0;
    rs_s    = 1'b0;
    data_s  = {LCD_DATA_W{1'b0}};
    long_s  = 1'b0;
    case (state_r)
      ST_PWRUP: begin
        if (cnt_r == CNT_ZERO) begin
          start_s = 1'b1;
          data_s  = init_cmd(3'd0);
          idx_n   = 3'd1;
          state_n = ST_INIT;
        end else begin
          cnt_n = cnt_r - CNT_ONE;
        end
      end
      ST_INIT: begin
        // Next init command is issued on the done cycle so writes run back to back.
        if (xfer_done_s) begin
          if (idx_r == INIT_LEN) begin
            state_n = ST_IDLE;
          end else begin
            start_s = 1'b1;
            data_s  = init_cmd(idx_r);
            long_s  = (init_cmd(idx_r) == CMD_CLEAR);
            idx_n   = idx_r + 3'd1;
          end
        end else begin
          state_n = ST_INIT;
        end
      end
      ST_IDLE: begin
        if (VLD_I && rdy_r) begin
          if (is_printable(DATA_I)) begin
            start_s = 1'b1;
            rs_s    = 1'b1;
            data_s  = DATA_I;
            col_n   = col_r + COL_ONE;
            state_n = ST_XFER;
          end else if (DATA_I == CHAR_CR) begin
            start_s = 1'b1;
            data_s  = CMD_DDRAM | line_base(line_r);
            col_n   = COL_ZERO;
            state_n = ST_XFER;
          end else if (DATA_I == CHAR_LF) begin
            start_s = 1'b1;
            data_s  = CMD_DDRAM | line_base(~line_r);
            line_n  = ~line_r;
            col_n   = COL_ZERO;
            state_n = ST_XFER;
          end else if (DATA_I == CHAR_FF) begin
            start_s = 1'b1;
            data_s  = CMD_CLEAR;
            long_s  = 1'b1;
            line_n  = 1'b0;
            col_n   = COL_ZERO;
            state_n = ST_XFER;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_IDLE;
        end
      end
      ST_XFER: begin
        // A character that filled the line chains the cursor move without an idle gap.
        if (xfer_done_s) begin
          if (col_r == COL_MAX) begin
            start_s = 1'b1;
            data_s  = CMD_DDRAM | line_base(~line_r);
            line_n  = ~line_r;
            col_n   = COL_ZERO;
            state_n = ST_WRAP;
          end else begin
            state_n = ST_IDLE;
          end
        end else begin
          state_n = ST_XFER;
        end
      end
      ST_WRAP: begin
        if (xfer_done_s) begin
          state_n = ST_IDLE;
        end else begin
          state_n = ST_WRAP;
        end
      end
      default: begin
        state_n = ST_PWRUP;
      end
    endcase
  end

  // State, counters and registered handshake outputs.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_r <= ST_PWRUP;
      cnt_r   <= PWRUP_LD;
      idx_r   <= 3'd0;
      col_r   <= COL_ZERO;
      line_r  <= 1'b0;
      rdy_r   <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_n;
      cnt_r   <= cnt_n;
      idx_r   <= idx_n;
      col_r   <= col_n;
      line_r  <= line_n;
      rdy_r   <= (state_n == ST_IDLE);
      drop_r  <= VLD_I && !rdy_r;
    end
  end

endmodule
